// File: rtl/spi_mem_controller.sv
// Transaction sequencer for the SPI memory datapath: decodes one command byte
// (7-bit address + R/W) and one data byte, and strobes the datapath registers.
module spi_mem_controller (
   input  logic       clk,
   input  logic       reset,
   input  logic       cs_cond,
   input  logic       sclk_pos,
   input  logic       sclk_neg,
   input  logic [7:0] sr_par_out,
   output logic       addr_we,
   output logic       sr_we,
   output logic       dm_we,
   output logic       miso_buf,
   output logic       txn_done,
   output logic       txn_abort,
   output logic       rw_flag,
   output logic [2:0] state,
   output logic [3:0] bit_count
);

   localparam logic [2:0] IDLE        = 3'd0;
   localparam logic [2:0] GET_ADDR    = 3'd1;
   localparam logic [2:0] LATCH_ADDR  = 3'd2;
   localparam logic [2:0] READ_LOAD   = 3'd3;
   localparam logic [2:0] READ_SHIFT  = 3'd4;
   localparam logic [2:0] WRITE_SHIFT = 3'd5;
   localparam logic [2:0] WRITE_MEM   = 3'd6;
   localparam logic [2:0] DONE        = 3'd7;

   logic [3:0] count_inc;
   logic       cs_abort;
   logic       unused_inputs;

   // The falling-edge strobe and address bits only matter to the datapath.
   assign unused_inputs = ^{sclk_neg, sr_par_out[7:1]};

   assign count_inc = (bit_count == 4'd8) ? 4'd8 : bit_count + 4'd1;
   assign cs_abort  = cs_cond && (state != IDLE) && (state != DONE);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state     <= IDLE;
         bit_count <= 4'd0;
         rw_flag   <= 1'b0;
         txn_done  <= 1'b0;
         txn_abort <= 1'b0;
      end else begin
         txn_done  <= 1'b0;
         txn_abort <= 1'b0;
         // Chip select wins over any same-cycle SCLK strobe.
         if (cs_abort) begin
            state     <= IDLE;
            bit_count <= 4'd0;
            txn_abort <= 1'b1;
         end else begin
            case (state)
               IDLE: begin
                  if (!cs_cond) begin
                     state     <= GET_ADDR;
                     bit_count <= 4'd0;
                  end
               end
               GET_ADDR: begin
                  if (sclk_pos) begin
                     bit_count <= count_inc;
                     if (count_inc == 4'd8) state <= LATCH_ADDR;
                  end
               end
               LATCH_ADDR: begin
                  rw_flag   <= sr_par_out[0];
                  bit_count <= 4'd0;
                  state     <= sr_par_out[0] ? READ_LOAD : WRITE_SHIFT;
               end
               READ_LOAD: state <= READ_SHIFT;
               READ_SHIFT: begin
                  if (sclk_pos) begin
                     bit_count <= count_inc;
                     if (count_inc == 4'd8) begin
                        state    <= DONE;
                        txn_done <= 1'b1;
                     end
                  end
               end
               WRITE_SHIFT: begin
                  if (sclk_pos) begin
                     bit_count <= count_inc;
                     if (count_inc == 4'd8) state <= WRITE_MEM;
                  end
               end
               WRITE_MEM: begin
                  state    <= DONE;
                  txn_done <= 1'b1;
               end
               DONE: begin
                  if (cs_cond) state <= IDLE;
               end
               default: state <= IDLE;
            endcase
         end
      end
   end

   assign addr_we  = (state == LATCH_ADDR);
   assign sr_we    = (state == READ_LOAD);
   assign dm_we    = (state == WRITE_MEM);
   assign miso_buf = (state == READ_LOAD) || (state == READ_SHIFT);

endmodule

// File: doc/spi_mem_controller.md
# spi_mem_controller

Transaction sequencer for the SPI memory datapath. Runs on the FPGA clock, consumes the conditioned chip-select and the one-cycle SCLK edge strobes from the input conditioners, and generates the address-latch, shift-register parallel-load, memory write-enable and MISO output-enable strobes. It decodes one SPI frame: a 7-bit address plus an R/W bit, followed by an 8-bit read or write data phase. It also reports completion and abort events for debug LEDs.

## Interface
- No parameters. Frame format is fixed: 8-bit command byte, 8-bit data byte.
- clk  in  1  FPGA clock; all state updates on its rising edge
- reset  in  1  asynchronous, active-high; forces IDLE and all outputs to 0
- cs_cond  in  1  conditioned chip select, active low
- sclk_pos  in  1  one-clk strobe, SCLK rising edge
- sclk_neg  in  1  one-clk strobe, SCLK falling edge (unused by the FSM; accepted only for port compatibility)
- sr_par_out  in  8  shift-register parallel output; bit 0 is the R/W flag (1 = read)
- addr_we  out  1  one-clk pulse; latches sr_par_out into the address register
- sr_we  out  1  one-clk pulse; parallel-loads memory data into the shift register
- dm_we  out  1  one-clk pulse; writes sr_par_out to memory
- miso_buf  out  1  MISO output enable; level, high during the read data phase
- txn_done  out  1  one-clk pulse on completion of a frame
- txn_abort  out  1  one-clk pulse when CS rises mid-frame
- rw_flag  out  1  R/W bit captured in LATCH_ADDR; holds until the next LATCH_ADDR
- state  out  3  current state encoding, for debug
- bit_count  out  4  SCLK rising edges counted in the current phase (0–8)

## Operation
- State encoding: IDLE=0, GET_ADDR=1, LATCH_ADDR=2, READ_LOAD=3, READ_SHIFT=4, WRITE_SHIFT=5, WRITE_MEM=6, DONE=7.
- Outputs are Moore-decoded from the registered state, except txn_done and txn_abort, which are registered pulses.
- IDLE: all strobes 0. If cs_cond==0, go to GET_ADDR and clear bit_count to 0.
- GET_ADDR: each sclk_pos increments bit_count. On the sclk_pos that makes bit_count 8, go to LATCH_ADDR.
- LATCH_ADDR (exactly 1 clk):
  - addr_we=1; rw_flag <= sr_par_out[0]; bit_count <= 0.
  - Next state is READ_LOAD if the captured bit is 1, otherwise WRITE_SHIFT.
- READ_LOAD (exactly 1 clk): sr_we=1, miso_buf=1, then go to READ_SHIFT.
- READ_SHIFT: miso_buf=1. Count sclk_pos; on the 8th, go to DONE and pulse txn_done.
- WRITE_SHIFT: count sclk_pos; on the 8th, go to WRITE_MEM.
- WRITE_MEM (exactly 1 clk): dm_we=1, then go to DONE and pulse txn_done.
- DONE: all strobes 0, miso_buf=0. Wait for cs_cond==1, then go to IDLE.
- CS abort:
  - cs_cond==1 in any state other than IDLE or DONE sends the FSM to IDLE on the next edge and pulses txn_abort.
  - CS has priority over a simultaneous sclk_pos: no counter increment, no addr_we, no dm_we.
- bit_count saturates at 8 and never wraps. Extra sclk_pos edges in DONE are ignored.
- Back-to-back frames need CS to return high. Without that, DONE holds and further sclk_pos edges are ignored.
- Reset mid-frame: immediate IDLE. No abort pulse. rw_flag and bit_count clear to 0.

## Timing
- Reset values: state=IDLE(0), addr_we=sr_we=dm_we=miso_buf=txn_done=txn_abort=rw_flag=0, bit_count=0.
- cs_cond falling to GET_ADDR: 1 clk.
- 8th address sclk_pos to addr_we: addr_we is high in the clk after the strobe cycle. This gives the shift register one clk to settle its 8th shift.
- Read path:
  - addr_we is followed by sr_we 1 clk later.
  - The memory read is combinational from the address register, so it is valid when sr_we samples.
  - miso_buf is asserted from the READ_LOAD cycle through the cycle of the 8th data sclk_pos.
- Write path: 8th data sclk_pos, then 1 clk to WRITE_MEM (dm_we high), then 1 clk to DONE with txn_done high.
- Requirement on the master: SCLK half-period ≥ 4 clk, so LATCH_ADDR and READ_LOAD finish before the next SCLK edge strobe.
- txn_done and txn_abort are never high in the same cycle. Each is exactly 1 clk wide.

## Test plan
- Write frame:
  - Stimulus: CS low, shift 0x2A (addr 0x15, W), then 0xC3, then CS high.
  - Response: addr_we pulses once with sr_par_out=0x2A and rw_flag=0. dm_we pulses once with sr_par_out=0xC3. Then txn_done, state DONE, then IDLE.
- Read frame:
  - Stimulus: after the write above, CS low, shift 0x2B (addr 0x15, R), clock 8 more bits.
  - Response: sr_we pulses 1 clk after addr_we. miso_buf is high for the data phase. MISO bits equal 0xC3 MSB first. dm_we never asserts.
- Abort:
  - Stimulus: CS high after 5 address bits.
  - Response: txn_abort pulses 1 clk later, state=IDLE, bit_count=0. No addr_we.
  - Repeat with CS rising on the same cycle as the 8th write-data sclk_pos. Required: no dm_we, txn_abort=1.
- Reset mid-read: assert reset during READ_SHIFT. All outputs go to 0 immediately, with no clk needed. After release, a fresh write frame completes normally.
- Overclock and CS hold:
  - Stimulus: after a completed write, hold CS low and send 4 extra sclk_pos.
  - Response: state stays DONE, bit_count=8, no strobes. CS high returns to IDLE in 1 clk with no abort.
